serial_add_sched: RTL and testbench
===================================

# serial_add_sched

Scheduler and sequencer for a shared bit-serial full-adder cell. Two requesters submit parallel WIDTH-bit operand pairs. The block grants one per operation using round-robin arbitration and shifts the operands LSB-first through the external full-adder cell, owning the carry flop. It reassembles the sum and returns it to the granted requester with a one-cycle done pulse. The block sits between parallel client logic and the single combinational full-adder cell that the clients time-share.

## Interface
- `WIDTH`, default 4: operand/result width in bits; legal range 2..32.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: request level per requester; `req[i]` high means requester i wants an add.
- `a0`, `b0` in WIDTH: requester 0 operands; sampled only on its grant edge.
- `a1`, `b1` in WIDTH: requester 1 operands; sampled only on its grant edge.
- `ack` out 2: registered one-cycle pulse; operands of requester i captured.
- `done` out 2: registered one-cycle pulse; `result`/`cout` valid for requester i.
- `result` out WIDTH: sum of the last completed operation; held until the next completion.
- `cout` out 1: carry-out of the last completed operation; held.
- `busy` out 1: high while state is SHIFT.
- `ser_a`, `ser_b` out 1: current operand bits to the adder cell.
- `ser_cin` out 1: current carry to the adder cell.
- `ser_sum`, `ser_cout` in 1: combinational sum/carry from the adder cell.

## Operation
- States: IDLE and SHIFT.
- Reset values:
  - state = IDLE.
  - `ack`, `done`, `result`, `cout`, `busy`, carry, bit count = 0.
  - Round-robin pointer `last` = 1, so requester 0 wins first.
- IDLE, on an edge with any `req` high:
  - Grant winner w. If only one requester is requesting, it wins. If both are requesting, w is the requester other than `last`.
  - Capture `a_w`/`b_w` into operand shift registers. Clear carry and count.
  - Set `last` = w and the owner register = w. `ack[w]` <= 1. Go to SHIFT.
- SHIFT, combinational outputs:
  - `ser_a` = opa[0], `ser_b` = opb[0], `ser_cin` = carry register.
  - In IDLE all three are 0.
- SHIFT, each edge:
  - opa and opb shift right.
  - Sum shift register shifts right with `ser_sum` entering the MSB.
  - Carry <= `ser_cout`. Count++.
- SHIFT, edge where count == WIDTH-1:
  - `result` <= {`ser_sum`, sumreg[WIDTH-1:1]}; `cout` <= `ser_cout`.
  - `done[owner]` <= 1. Go to IDLE.
- Arithmetic: unsigned modulo 2^WIDTH; `cout` is the true carry-out.
- A new grant in IDLE can occur on the edge following completion, in the same cycle `done` is high.
- Requester obligations:
  - A requester must drop `req` before the block next returns to IDLE (at least WIDTH cycles after `ack`). A `req` still high at that point is a new request.
  - Operand stability is required only on the grant edge.
- `req` changes during SHIFT are ignored.
- Reset mid-operation:
  - Everything clears immediately. The in-flight operation is discarded and no `done` is issued.
  - The pointer returns to its reset value.

## Timing
- Request seen high in IDLE at edge E0 → `ack` high for the cycle after E0.
- Shift edges are E1..E_WIDTH. `done` and the new `result` are visible in the cycle after E_WIDTH.
- Latency from `ack` to `done`: WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles under continuous load.
- With both requesters continuously requesting, grants alternate 0,1,0,1…

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Adds output `ovf` (1 bit, reset 0, held like `result`).
  - `ovf` = two's-complement overflow = carry register ^ `ser_cout` at the final shift edge, captured with `result`.
- `SERIAL_ADD_OVF_EN` undefined: no `ovf` port and no overflow logic; all other behaviour is identical.

## Test plan
- WIDTH=4, `req[0]` with a0=5, b0=6 at E0:
  - `ack[0]` high in cycle 1 and `done[0]` high in cycle 5.
  - `result`=4'hB, `cout`=0.
  - `ser_a` sequence is 1,0,1,0 and `ser_cin` is 0 in the first shift cycle.
- `req[1]` with a1=4'hF, b1=4'h1 → `result`=0, `cout`=1. With `SERIAL_ADD_OVF_EN`: `ovf`=0. Then a1=7, b1=1 → `result`=8, `cout`=0, `ovf`=1.
- Both `req` high from reset and held:
  - `ack[0]` in cycle 1 and `done[0]` in cycle 5.
  - `ack[1]` in cycle 6 and `done[1]` in cycle 10.
  - Then requester 0 again; strict alternation for 8 operations.
- `rst_n` pulsed low during SHIFT, second shift cycle:
  - All outputs go to 0 asynchronously and no `done` follows.
  - A subsequent `req`=2'b11 grants requester 0 first.
- Back-to-back: `req[0]` re-asserted during its own `done` cycle → next `ack[0]` in the following cycle, giving a 5-cycle period, and `result` holds the previous value until the new `done`.

Source files
------------

// File: rtl/serial_add_sched.sv
// Round-robin scheduler/sequencer that time-shares one external bit-serial full-adder cell
// between two requesters. Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       ack,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  input  logic             ser_sum,
  input  logic             ser_cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic             grant_w;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sum_d    = sum_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    last_d   = last_q;
    owner_d  = owner_q;
    ack_d    = 2'b00;
    done_d   = 2'b00;
    grant_w  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          // With both requesting, the one that did not win last time goes next.
          grant_w        = (req == 2'b11) ? ~last_q : req[1];
          opa_d          = grant_w ? a1 : a0;
          opb_d          = grant_w ? b1 : b0;
          carry_d        = 1'b0;
          cnt_d          = '0;
          last_d         = grant_w;
          owner_d        = grant_w;
          ack_d[grant_w] = 1'b1;
          state_d        = SHIFT;
        end
      end
      SHIFT: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sum_d   = {ser_sum, sum_q[WIDTH-1:1]};
        carry_d = ser_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d        = {ser_sum, sum_q[WIDTH-1:1]};
          cout_d          = ser_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d           = carry_q ^ ser_cout;
`endif
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign ser_a   = busy & opa_q[0];
  assign ser_b   = busy & opb_q[0];
  assign ser_cin = busy & carry_q;
  assign ack     = ack_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level timeline model of the scheduler.
module tb_serial_add_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   ack, done;
  logic [W-1:0] result;
  logic         cout, busy, ser_a, ser_b, ser_cin, ser_sum, ser_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a0       (a0),
    .b0       (b0),
    .a1       (a1),
    .b1       (b1),
    .ack      (ack),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .busy     (busy),
    .ser_a    (ser_a),
    .ser_b    (ser_b),
    .ser_cin  (ser_cin),
`ifdef SERIAL_ADD_OVF_EN
    .ovf      (ovf),
`endif
    .ser_sum  (ser_sum),
    .ser_cout (ser_cout)
  );

  // The shared combinational full-adder cell.
  assign ser_sum  = ser_a ^ ser_b ^ ser_cin;
  assign ser_cout = (ser_a & ser_b) | (ser_a & ser_cin) | (ser_b & ser_cin);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a grant occupies the block for W shift edges, then the sum a+b is delivered.
  logic [1:0]   e_ack = 2'b00, e_done = 2'b00;
  logic [W-1:0] e_result = '0;
  logic         e_cout = 1'b0, e_ovf = 1'b0;
  logic         m_busy = 1'b0;
  int           m_steps = 0, m_owner = 0, m_last = 1;
  logic [W-1:0] m_a = '0, m_b = '0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0]   n_ack, n_done;
    longint       s;
    logic [W-1:0] lo;
    int           w;
    if (!rst_n) begin
      e_ack <= 2'b00; e_done <= 2'b00; e_result <= '0; e_cout <= 1'b0; e_ovf <= 1'b0;
      m_busy <= 1'b0; m_steps <= 0; m_owner <= 0; m_last <= 1; m_a <= '0; m_b <= '0;
    end else begin
      n_ack  = 2'b00;
      n_done = 2'b00;
      if (m_busy) begin
        if (m_steps + 1 == W) begin
          s  = longint'(m_a) + longint'(m_b);
          lo = W'(s);
          e_result <= lo;
          e_cout   <= s[W];
          e_ovf    <= (m_a[W-1] == m_b[W-1]) && (lo[W-1] != m_a[W-1]);
          n_done[m_owner] = 1'b1;
          m_busy <= 1'b0;
        end
        m_steps <= m_steps + 1;
      end else if (req != 2'b00) begin
        w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        m_a     <= (w == 1) ? a1 : a0;
        m_b     <= (w == 1) ? b1 : b0;
        m_last  <= w;
        m_owner <= w;
        n_ack[w] = 1'b1;
        m_busy  <= 1'b1;
        m_steps <= 0;
      end
      e_ack  <= n_ack;
      e_done <= n_done;
    end
  end

  always @(negedge clk) begin : compare
    longint mask, e_cin;
    mask  = (64'd1 << m_steps) - 1;
    e_cin = ((longint'(m_a) & mask) + (longint'(m_b) & mask)) >> m_steps;
    check("ack", ack, e_ack);
    check("done", done, e_done);
    check("result", result, e_result);
    check("cout", cout, e_cout);
    check("busy", busy, m_busy);
    check("ser_a", ser_a, m_busy ? m_a[m_steps] : 1'b0);
    check("ser_b", ser_b, m_busy ? m_b[m_steps] : 1'b0);
    check("ser_cin", ser_cin, m_busy ? e_cin[0] : 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", ovf, e_ovf);
`endif
  end

  // Issues one request from idle and returns the cycle numbers of ack and done (-1 if missing).
  task automatic run_op(input int w, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int ack_c, output int done_c,
                        output logic [31:0] sa_log, output logic [31:0] cin_log);
    ack_c = -1; done_c = -1; sa_log = '0; cin_log = '0;
    if (w == 0) begin a0 = a; b0 = b; req = 2'b01; end
    else        begin a1 = a; b1 = b; req = 2'b10; end
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (c <= 32) begin sa_log[c-1] = ser_a; cin_log[c-1] = ser_cin; end
      if (ack[w] && ack_c < 0) begin ack_c = c; req = 2'b00; end
      if (done[w]) begin done_c = c; break; end
    end
    req = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ack_c, done_c;
    logic [31:0] sa_log, cin_log;
    rst_n = 1'b0; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {ack, done, result, cout, busy}, '0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 5 + 6 from requester 0
    run_op(0, 4'd5, 4'd6, ack_c, done_c, sa_log, cin_log);
    check("t1_ack_cycle", ack_c, 1);
    check("t1_done_cycle", done_c, 5);
    check("t1_result", result, 4'hB);
    check("t1_cout", cout, 1'b0);
    check("t1_ser_a_seq", sa_log[3:0], 4'b0101);
    check("t1_cin_first", cin_log[0], 1'b0);

    // F + 1 then 7 + 1 from requester 1
    run_op(1, 4'hF, 4'h1, ack_c, done_c, sa_log, cin_log);
    check("t2a_done_cycle", done_c, 5);
    check("t2a_result", result, 4'h0);
    check("t2a_cout", cout, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    check("t2a_ovf", ovf, 1'b0);
`endif
    run_op(1, 4'h7, 4'h1, ack_c, done_c, sa_log, cin_log);
    check("t2b_done_cycle", done_c, 5);
    check("t2b_result", result, 4'h8);
    check("t2b_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("t2b_ovf", ovf, 1'b1);
`endif

    // Back-to-back: re-request in the done cycle, previous result held until the new done
    run_op(0, 4'd3, 4'd4, ack_c, done_c, sa_log, cin_log);
    check("t3_first_result", result, 4'd7);
    a0 = 4'd9; b0 = 4'd9; req = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t3_ack_next_cycle", ack, 2'b01);
        req = 2'b00;
      end
      if (c < 5) check("t3_result_held", result, 4'd7);
      else begin
        check("t3_done", done, 2'b01);
        check("t3_result", result, 4'd2);
        check("t3_cout", cout, 1'b1);
      end
    end

    // Both requesters held high from reset: strict alternation, 5-cycle period
    apply_reset();
    req = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c % 5 == 1) check("t4_ack_alt", ack, (((c - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10);
      if (c % 5 == 0) check("t4_done_alt", done, (((c - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10);
    end
    req = 2'b00;
    repeat (2) @(negedge clk);

    // Reset in the second shift cycle: outputs clear at once, no done, pointer restored
    run_op(0, 4'd2, 4'd3, ack_c, done_c, sa_log, cin_log);
    check("t5_pre_result", result, 4'd5);
    a0 = 4'd1; b0 = 4'd1; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_clear", {ack, done, result, cout, busy}, '0);
    check("t5_async_ser", {ser_a, ser_b, ser_cin}, 3'b000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      check("t5_no_done", done, 2'b00);
    end
    req = 2'b11;
    @(negedge clk);
    check("t5_ptr_reset_grant0", ack, 2'b01);
    req = 2'b00;
    repeat (W + 2) @(negedge clk);

    // Randomized traffic with occasional resets; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      if ($urandom_range(0, 599) == 0) #2 rst_n = 1'b0;
      else if (!rst_n) #2 rst_n = 1'b1;
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    req = 2'b00;
    repeat (2 * W) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
